move_queue: RTL and testbench

MOVE_QUEUE -- requirements
Module: move_queue

---
 rtl/move_queue.sv | 189 ++++++++++++++++++
 tb/tb_move_queue.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_queue.sv
// ---------------------------------------------------------------------------
// move_queue
//   Buffers move descriptors in a FIFO and hands them to a data mover one at a
//   time. Each descriptor is validated on acceptance. Invalid descriptors are
//   dropped and counted, and they set a sticky error flag. Valid descriptors
//   are queued, then issued in order with a one-cycle dm_start pulse. The
//   issue FSM waits for dm_idle before it pops the next descriptor.
//
// Ports
//   clk            : single clock for all logic
//   reset          : synchronous, active-high
//   desc_src       : source byte address of the incoming descriptor
//   desc_dst       : destination byte address of the incoming descriptor
//   desc_bytes     : move length in bytes
//   desc_burst     : burst size in bytes (power of two, 4..4096)
//   desc_valid     : descriptor handshake, valid side
//   desc_ready     : descriptor handshake, ready side (high while FIFO not full)
//   dm_src_address : registered move parameter for the data mover
//   dm_dst_address : registered move parameter for the data mover
//   dm_byte_count  : registered move parameter for the data mover
//   dm_burst_size  : registered move parameter for the data mover
//   dm_start       : one-cycle start pulse to the data mover
//   dm_idle        : data-mover idle status, sampled only while waiting
//   queued         : FIFO occupancy
//   busy           : FIFO non-empty or a move is being issued or waited on
//   completed      : count of finished moves (wraps)
//   rejected       : count of dropped descriptors (wraps)
//   error          : sticky flag, set by any rejected descriptor
// ---------------------------------------------------------------------------
module move_queue #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [63:0]              desc_src,
   input  logic [63:0]              desc_dst,
   input  logic [63:0]              desc_bytes,
   input  logic [12:0]              desc_burst,
   input  logic                     desc_valid,
   output logic                     desc_ready,
   output logic [63:0]              dm_src_address,
   output logic [63:0]              dm_dst_address,
   output logic [63:0]              dm_byte_count,
   output logic [12:0]              dm_burst_size,
   output logic                     dm_start,
   input  logic                     dm_idle,
   output logic [$clog2(DEPTH):0]   queued,
   output logic                     busy,
   output logic [31:0]              completed,
   output logic [31:0]              rejected,
   output logic                     error
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   typedef struct packed {
      logic [63:0] src;
      logic [63:0] dst;
      logic [63:0] bytes;
      logic [12:0] burst;
   } desc_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT
   } state_t;

   state_t          state, state_next;
   desc_t           mem [DEPTH];
   desc_t           head;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;

   logic [12:0]     burst_mask;
   logic            burst_ok;
   logic            bytes_aligned;
   logic            desc_ok;
   logic            accept;
   logic            push;
   logic            drop;
   logic            pop;
   logic            complete;

   // ---------------- descriptor validation ----------------
   // A 13-bit power of two is at most 4096, so "power of two and >= 4"
   // covers the whole legal burst set. Alignment only needs the low 13 bits.
   assign burst_mask    = desc_burst - 13'd1;
   assign burst_ok      = (desc_burst >= 13'd4) && ((desc_burst & burst_mask) == 13'd0);
   assign bytes_aligned = (desc_bytes[12:0] & burst_mask) == 13'd0;
   assign desc_ok       = burst_ok && (desc_bytes != 64'd0) && bytes_aligned;

   // Ready depends only on the registered count, so there is no bypass when full.
   assign desc_ready = (count != FULL_COUNT);
   assign accept     = desc_valid && desc_ready;
   assign push       = accept && desc_ok;
   assign drop       = accept && !desc_ok;

   assign head = mem[rd_ptr];

   // ---------------- issue FSM: next state ----------------
   // NOTE: every signal driven here gets a default first so no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         S_IDLE: begin
            if (count != '0) begin
               pop        = 1'b1;
               state_next = S_START;
            end
         end
         S_START: state_next = S_WAIT;
         S_WAIT: begin
            if (dm_idle) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign complete = (state == S_WAIT) && dm_idle;

   // ---------------- issue FSM: state register ----------------
   // NOTE: sequential state uses non-blocking assignments, so every register
   // samples the values from before the edge, whatever the statement order.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // dm_start is a decode of the START state: it is high for exactly one cycle.
   assign dm_start = (state == S_START);

   // ---------------- FIFO storage ----------------
   // NOTE: the storage array is not reset. Occupancy is tracked by the pointers
   // and count, and no entry is read before it is written.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{src: desc_src, dst: desc_dst,
                                 bytes: desc_bytes, burst: desc_burst};
   end

   // ---------------- FIFO control, counters, move parameters ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         completed      <= '0;
         rejected       <= '0;
         error          <= 1'b0;
         dm_src_address <= '0;
         dm_dst_address <= '0;
         dm_byte_count  <= '0;
         dm_burst_size  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);

         // A push and a pop on the same edge leave the occupancy unchanged.
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase

         if (drop) begin
            rejected <= rejected + 32'd1;
            error    <= 1'b1;
         end

         if (complete) completed <= completed + 32'd1;

         // The parameters stay unchanged until the next pop, so the mover sees
         // stable values for the whole move.
         if (pop) begin
            dm_src_address <= head.src;
            dm_dst_address <= head.dst;
            dm_byte_count  <= head.bytes;
            dm_burst_size  <= head.burst;
         end
      end
   end

   assign queued = count;
   assign busy   = (count != '0) || (state != S_IDLE);

endmodule

// File: tb/tb_move_queue.sv
// ---------------------------------------------------------------------------
// tb_move_queue
//   Self-checking bench for move_queue. A transaction-level model holds the
//   queue of accepted descriptors, the running counters, and whether the
//   engine is free. A model data mover takes a random number of cycles per
//   move. Every cycle, the outputs sampled on the falling edge are compared
//   with the model. Directed phases cover a single move, rejection, a full
//   FIFO and a reset mid-move. A long random phase mixes valid and invalid
//   descriptors with short mover delays.
// ---------------------------------------------------------------------------
module tb_move_queue;

   localparam int DEPTH = 8;
   localparam int QW    = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic [63:0] src;
      logic [63:0] dst;
      logic [63:0] bytes;
      logic [12:0] burst;
   } desc_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [63:0]   desc_src, desc_dst, desc_bytes;
   logic [12:0]   desc_burst;
   logic          desc_valid;
   logic          desc_ready;
   logic [63:0]   dm_src_address, dm_dst_address, dm_byte_count;
   logic [12:0]   dm_burst_size;
   logic          dm_start;
   logic          dm_idle;
   logic [QW-1:0] queued;
   logic          busy;
   logic [31:0]   completed, rejected;
   logic          error;

   move_queue #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .desc_src       (desc_src),
      .desc_dst       (desc_dst),
      .desc_bytes     (desc_bytes),
      .desc_burst     (desc_burst),
      .desc_valid     (desc_valid),
      .desc_ready     (desc_ready),
      .dm_src_address (dm_src_address),
      .dm_dst_address (dm_dst_address),
      .dm_byte_count  (dm_byte_count),
      .dm_burst_size  (dm_burst_size),
      .dm_start       (dm_start),
      .dm_idle        (dm_idle),
      .queued         (queued),
      .busy           (busy),
      .completed      (completed),
      .rejected       (rejected),
      .error          (error)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model state ----------------
   desc_t   mq[$];          // accepted, not yet issued, in push order
   desc_t   dir_q[$];       // directed descriptors waiting to be driven
   desc_t   cur;            // parameters of the last issued move
   bit      free;           // engine can pop in the current cycle
   int      exp_completed;
   int      exp_rejected;
   bit      exp_error;
   bit      exp_start;
   bit      push_req;       // descriptor presented this cycle will be taken
   bit      push_ok;
   desc_t   push_d;
   bit      complete_req;   // mover reports idle while the move is pending
   bit      outstanding;
   int      cnt;
   int      min_delay, max_delay, push_pct, valid_pct;

   // Legal burst set is {4, 8, ..., 4096}; the length must be a non-zero
   // multiple of the burst.
   function automatic bit model_ok(desc_t d);
      bit p = 1'b0;
      for (int s = 4; s <= 4096; s *= 2)
         if (int'(d.burst) == s) p = 1'b1;
      return p && (d.bytes != 64'd0) && ((d.bytes % 64'(d.burst)) == 64'd0);
   endfunction

   function automatic desc_t rand_desc(bit want_valid);
      desc_t d;
      d.src   = {$urandom, $urandom};
      d.dst   = {$urandom, $urandom};
      d.burst = 13'(4 << $urandom_range(0, 10));
      d.bytes = 64'(d.burst) * 64'($urandom_range(1, 4096));
      if (!want_valid) begin
         case ($urandom_range(0, 3))
            0:       d.bytes = 64'd0;
            1:       d.bytes = d.bytes + 64'($urandom_range(1, int'(d.burst) - 1));
            2:       d.burst = 13'($urandom_range(0, 3));
            default: d.burst = d.burst | 13'd1;
         endcase
      end
      return d;
   endfunction

   task automatic drive_desc(desc_t d);
      desc_src   = d.src;
      desc_dst   = d.dst;
      desc_bytes = d.bytes;
      desc_burst = d.burst;
   endtask

   // One clock cycle: advance the model across the rising edge, compare on the
   // falling edge, then drive inputs for the next cycle.
   task automatic step();
      desc_t d;
      @(negedge clk);
      exp_start = free && (mq.size() > 0);
      if (exp_start) cur = mq.pop_front();
      if (push_req) begin
         if (push_ok) mq.push_back(push_d);
         else begin
            exp_rejected++;
            exp_error = 1'b1;
         end
      end
      if (complete_req) begin
         exp_completed++;
         free = 1'b1;
      end
      if (exp_start) free = 1'b0;

      check("dm_start",   dm_start,       exp_start);
      check("dm_src",     dm_src_address, cur.src);
      check("dm_dst",     dm_dst_address, cur.dst);
      check("dm_bytes",   dm_byte_count,  cur.bytes);
      check("dm_burst",   dm_burst_size,  cur.burst);
      check("queued",     queued,         mq.size());
      check("desc_ready", desc_ready,     mq.size() != DEPTH);
      check("busy",       busy,           (mq.size() != 0) || !free);
      check("completed",  completed,      exp_completed);
      check("rejected",   rejected,       exp_rejected);
      check("error",      error,          exp_error);

      // model data mover
      if (exp_start) begin
         outstanding = 1'b1;
         cnt         = $urandom_range(min_delay, max_delay);
         dm_idle     = 1'b0;
      end else if (outstanding) begin
         cnt--;
         if (cnt == 0) begin
            dm_idle     = 1'b1;
            outstanding = 1'b0;
         end
      end
      complete_req = dm_idle && !free && !exp_start;

      // descriptor source: a descriptor that was refused stays on the bus
      if (!(desc_valid && !push_req)) begin
         if (dir_q.size() > 0) begin
            drive_desc(dir_q.pop_front());
            desc_valid = 1'b1;
         end else if ($urandom_range(0, 99) < push_pct) begin
            d = rand_desc($urandom_range(0, 99) < valid_pct);
            drive_desc(d);
            desc_valid = 1'b1;
         end else begin
            drive_desc(rand_desc(1'b1));
            desc_valid = 1'b0;
         end
      end
      push_req = desc_valid && (mq.size() != DEPTH);
      push_d   = '{src: desc_src, dst: desc_dst, bytes: desc_bytes, burst: desc_burst};
      push_ok  = model_ok(push_d);
   endtask

   // One-cycle synchronous reset, then the first-cycle-after-reset checks.
   task automatic do_reset();
      @(negedge clk);
      reset      = 1'b1;
      desc_valid = 1'b0;
      @(negedge clk);
      mq.delete();
      cur           = '0;
      free          = 1'b1;
      exp_completed = 0;
      exp_rejected  = 0;
      exp_error     = 1'b0;
      push_req      = 1'b0;
      complete_req  = 1'b0;
      outstanding   = 1'b0;
      dm_idle       = 1'b1;
      check("rst_queued",     queued,     0);
      check("rst_desc_ready", desc_ready, 1);
      check("rst_busy",       busy,       0);
      check("rst_dm_start",   dm_start,   0);
      check("rst_completed",  completed,  0);
      check("rst_rejected",   rejected,   0);
      check("rst_error",      error,      0);
      check("rst_dm_src",     dm_src_address, 0);
      check("rst_dm_burst",   dm_burst_size,  0);
      reset = 1'b0;
   endtask

   initial begin
      bit setup_ok;
      reset      = 1'b1;
      desc_valid = 1'b0;
      dm_idle    = 1'b1;
      drive_desc('0);
      free       = 1'b1;
      min_delay  = 1;
      max_delay  = 1;
      push_pct   = 0;
      valid_pct  = 100;
      do_reset();

      // single move, mover busy for 20 cycles
      min_delay = 20;
      max_delay = 20;
      dir_q.push_back('{src: 64'h1000, dst: 64'h8000, bytes: 64'd4096, burst: 13'd256});
      repeat (40) step();
      check("single_completed", completed, 1);
      check("single_busy",      busy,      0);

      // three rejections: misaligned length, illegal burst, zero length
      dir_q.push_back('{src: 64'h10, dst: 64'h20, bytes: 64'd1000, burst: 13'd256});
      dir_q.push_back('{src: 64'h30, dst: 64'h40, bytes: 64'd4096, burst: 13'd100});
      dir_q.push_back('{src: 64'h50, dst: 64'h60, bytes: 64'd0,    burst: 13'd256});
      repeat (10) step();
      check("reject_count",  rejected,  1 + 3 - 1);
      check("reject_error",  error,     1);
      check("reject_queued", queued,    0);
      do_reset();

      // full FIFO: long mover delay, valid descriptors every cycle
      min_delay = 200;
      max_delay = 200;
      push_pct  = 100;
      valid_pct = 100;
      repeat (20) step();
      check("full_queued", queued,     DEPTH);
      check("full_ready",  desc_ready, 0);
      repeat (240) step();

      // random traffic with short mover delays
      min_delay = 1;
      max_delay = 6;
      push_pct  = 50;
      valid_pct = 80;
      repeat (1500) step();

      // reset while a move is in flight with entries still queued
      min_delay = 50;
      max_delay = 50;
      push_pct  = 100;
      valid_pct = 100;
      setup_ok  = 1'b0;
      for (int i = 0; i < 200 && !setup_ok; i++) begin
         step();
         setup_ok = outstanding && !exp_start && (mq.size() >= 2);
      end
      check("midwait_setup", setup_ok, 1);
      push_pct = 0;
      do_reset();
      repeat (30) step();
      check("midwait_completed", completed, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
